// File: rtl/jk_input_conditioner.sv
// ============================================================================
// Module      : jk_input_conditioner
// Description : Four-channel synchroniser and debouncer for the JK flip-flop inputs.
//               Optional macro JK_INPUT_CONDITIONER_STROBE_EN builds the change strobes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jk_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       input_clock1_c_1,
  input  logic       input_reset1_rst_2,
  input  logic       input_switch1_j_3,
  input  logic       input_switch2_k_4,
  input  logic       input_switch3_preset_n_5,
  input  logic       input_switch4_clear_n_6,
  output logic       output_j_0_7,
  output logic       output_k_0_8,
  output logic       output_preset_n_0_9,
  output logic       output_clear_n_0_10,
  output logic [3:0] output_strobe_0_11,
  output logic       output_conflict_0_12
);

  // Channel order {clear_n, preset_n, k, j}; active-low controls idle high.
  localparam logic [3:0]       IDLE     = 4'b1100;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       clk;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] stable;
  logic [3:0] change;
  logic       conflict;

  assign clk = input_clock1_c_1;
  assign rst = input_reset1_rst_2;
  assign raw = {input_switch4_clear_n_6, input_switch3_preset_n_5,
                input_switch2_k_4, input_switch1_j_3};

  generate
    for (genvar ch = 0; ch < 4; ch++) begin : g_chan
      logic             s1;
      logic             s2;
      logic [CNT_W-1:0] cnt;
      logic             level;

      // A change commits on the edge the counter has already seen DEBOUNCE_CYCLES-1 mismatches.
      assign change[ch] = (s2 != level) && (cnt == CNT_LAST);
      assign stable[ch] = level;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1    <= IDLE[ch];
          s2    <= IDLE[ch];
          level <= IDLE[ch];
          cnt   <= '0;
        end else begin
          s1 <= raw[ch];
          s2 <= s1;
          if (s2 == level) begin
            cnt <= '0;
          end else if (change[ch]) begin
            level <= s2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict <= 1'b0;
    end else begin
      conflict <= ~stable[2] & ~stable[3];
    end
  end

`ifdef JK_INPUT_CONDITIONER_STROBE_EN
  logic [3:0] strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= 4'b0000;
    end else begin
      strobe <= change;
    end
  end

  assign output_strobe_0_11 = strobe;
`else
  assign output_strobe_0_11 = 4'b0000;
`endif

  assign output_j_0_7         = stable[0];
  assign output_k_0_8         = stable[1];
  assign output_preset_n_0_9  = stable[2];
  assign output_clear_n_0_10  = stable[3];
  assign output_conflict_0_12 = conflict;

endmodule

`default_nettype wire
